seg7_scan_disp: RTL

- Display back-end fed by the 32-bit display-select multiplexer; consumes its 32-bit word and drives the 8-digit multiplexed seven-segment display.
- Latches the word on `load`, time-multiplexes the eight hex digits, and decodes each nibble to segments.
- Supports per-digit decimal points, per-digit blanking, leading-zero suppression and whole-display blinking.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_disp.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment display back-end.
// Font entries are active-high with segment a on bit 0.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [7:0] ALL_OFF = 8'hFF;

  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (a on bit 0, lowercase b/d).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = ~HEX_FONT[i_nibble];

endmodule

// File: rtl/seg7_scan_disp.sv
// Eight-digit multiplexed hex display driver: latches a 32-bit word and scans it out
// with per-digit decimal points, blanking, leading-zero suppression and blinking.
module seg7_scan_disp
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 17,
  parameter int unsigned BLINK_DIV = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blank_in,
  input  logic        lz_en,
  input  logic        blink_en,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam logic [SCAN_DIV-1:0]  PRESC_ONE = SCAN_DIV'(1);
  localparam logic [BLINK_DIV-1:0] BLINK_ONE = BLINK_DIV'(1);

  logic [31:0]          r_data;
  logic [7:0]           r_point;
  logic [7:0]           r_blank;
  logic [SCAN_DIV-1:0]  r_presc;
  logic [2:0]           r_idx;
  logic [BLINK_DIV-1:0] r_blink_cnt;
  logic                 r_phase;
  logic [7:0]           r_an;
  logic [7:0]           r_seg;

  logic       w_tick;
  logic [2:0] w_idx_nxt;
  logic [3:0] w_nibble;
  logic [6:0] w_seg_n;
  logic [2:0] w_top;
  logic       w_dark;
  logic [7:0] w_an_nxt;
  logic [7:0] w_seg_nxt;

  assign w_tick    = &r_presc;
  assign w_idx_nxt = r_idx + 3'd1;
  assign w_nibble  = r_data[{w_idx_nxt, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_n)
  );

  // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 always shows.
  always_comb begin
    w_top = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_data[4*k +: 4] != 4'h0) begin
        w_top = 3'(k);
      end
    end
  end

  always_comb begin
    w_dark = r_blank[w_idx_nxt]
           | (lz_en && (w_idx_nxt > w_top))
           | (blink_en & r_phase);
    if (w_dark) begin
      w_an_nxt  = ALL_OFF;
      w_seg_nxt = ALL_OFF;
    end else begin
      w_an_nxt  = ~(8'b1 << w_idx_nxt);
      w_seg_nxt = {~r_point[w_idx_nxt], w_seg_n};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= 32'h0;
      r_point <= 8'h0;
      r_blank <= 8'h0;
    end else if (load) begin
      r_data  <= data_in;
      r_point <= point_in;
      r_blank <= blank_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_presc     <= r_presc + PRESC_ONE;
      r_blink_cnt <= r_blink_cnt + BLINK_ONE;
      if (&r_blink_cnt) begin
        r_phase <= ~r_phase;
      end
    end
  end

  // Outputs only move on a tick so a digit slot never glitches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx <= 3'd0;
      r_an  <= ALL_OFF;
      r_seg <= ALL_OFF;
    end else if (w_tick) begin
      r_idx <= w_idx_nxt;
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
